// File: rtl/seq_scan_ctrl_pkg.sv
// seq_scan_ctrl_pkg
//   Shared constants and FSM encoding for the serial pattern scanner.
//   DEF_W  : default word width / pattern length in bits
//   DEF_CW : default hit-counter width
package seq_scan_ctrl_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_CW = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_scan_ctrl_match.sv
// seq_match
//   W-bit history window, saturating fill count and comparator.
//   Ports:
//     CLK, RST  : clock, synchronous active-high reset
//     BVLD      : a new serial bit is presented this cycle
//     BIT       : serial bit (oldest bit ends up in MSB of the window)
//     PAT       : pattern to compare against
//     FILL_CLR  : zero the fill count (history itself is kept)
//     HIT       : one-cycle pulse after the edge that completed a match
module seq_match #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BVLD,
    input  logic         BIT,
    input  logic [W-1:0] PAT,
    input  logic         FILL_CLR,
    output logic         HIT
);

    localparam int FW = $clog2(W + 1);

    logic [W-1:0]  r_hist;
    logic [FW-1:0] r_fill;
    logic          r_hit;
    logic [W-1:0]  w_hist_nxt;
    logic [FW-1:0] w_fill_nxt;

    // Compare against the post-shift window so HIT lands in the cycle
    // right after the completing edge.
    always_comb begin
        w_hist_nxt = {r_hist[W-2:0], BIT};
        w_fill_nxt = (r_fill == FW'(W)) ? r_fill : r_fill + FW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hist <= '0;
            r_fill <= '0;
            r_hit  <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (FILL_CLR) begin
                r_fill <= '0;
            end else if (BVLD) begin
                r_hist <= w_hist_nxt;
                r_fill <= w_fill_nxt;
                r_hit  <= (w_hist_nxt == PAT) && (w_fill_nxt == FW'(W));
            end
        end
    end

    assign HIT = r_hit;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Accepts W-bit words, serializes them MSB first into seq_match and
//   keeps a saturating hit count with a sticky threshold interrupt.
//   Ports:
//     CLK, RST        : clock, synchronous active-high reset
//     EN              : scan enable, gates acceptance of new words
//     PDIN/PVLD/PRDY  : parallel word handshake
//     PAT/PAT_LD      : pattern load (honoured only in IDLE)
//     THR/IRQ_CLR     : interrupt threshold / clear of IRQ and count
//     HIT/CNT/IRQ     : match pulse, saturating count, sticky interrupt
//     BUSY            : a word is being shifted
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [W-1:0]  PDIN,
    input  logic          PVLD,
    output logic          PRDY,
    input  logic [W-1:0]  PAT,
    input  logic          PAT_LD,
    input  logic [CW-1:0] THR,
    input  logic          IRQ_CLR,
    output logic          HIT,
    output logic [CW-1:0] CNT,
    output logic          IRQ,
    output logic          BUSY
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_word;
    logic [BW-1:0] r_bcnt;
    logic [W-1:0]  r_pat;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_irq, w_irq_nxt;
    logic          w_hs;
    logic          w_hit;
    logic          w_fill_clr;

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        PRDY        = 1'b0;
        BUSY        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                PRDY = EN && !RST;
                if (PVLD && PRDY) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                BUSY = 1'b1;
                // Ready again in the last bit cycle so words stream gap-free.
                PRDY = EN && !RST && (r_bcnt == '0);
                if (r_bcnt == '0) w_state_nxt = (PVLD && PRDY) ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_hs = PVLD && PRDY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_word <= PDIN;
                r_bcnt <= BW'(W - 1);
            end else if (r_state == ST_SHIFT) begin
                r_bcnt <= r_bcnt - BW'(1);
            end
        end
    end

    assign w_fill_clr = PAT_LD && (r_state == ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST)             r_pat <= '0;
        else if (w_fill_clr) r_pat <= PAT;
    end

    seq_match #(.W(W)) u_match (
        .CLK      (CLK),
        .RST      (RST),
        .BVLD     (r_state == ST_SHIFT),
        .BIT      (r_word[r_bcnt]),
        .PAT      (r_pat),
        .FILL_CLR (w_fill_clr),
        .HIT      (w_hit)
    );

    // A hit coinciding with IRQ_CLR survives as a count of one.
    always_comb begin
        if (IRQ_CLR)    w_cnt_nxt = w_hit ? CW'(1) : '0;
        else if (w_hit) w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
        else            w_cnt_nxt = r_cnt;
        w_irq_nxt = (r_irq && !IRQ_CLR) || ((THR != '0) && (w_cnt_nxt >= THR));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_irq <= w_irq_nxt;
        end
    end

    assign HIT = w_hit;
    assign CNT = r_cnt;
    assign IRQ = r_irq;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST, EN, PVLD, PAT_LD, IRQ_CLR;
    logic [W-1:0]  PDIN, PAT;
    logic [CW-1:0] THR;
    logic          PRDY, HIT, IRQ, BUSY;
    logic [CW-1:0] CNT;

    int total = 0;
    int bad   = 0;
    logic [16:0] hits;

    seq_scan_ctrl #(.W(W), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .PDIN(PDIN), .PVLD(PVLD), .PRDY(PRDY),
        .PAT(PAT), .PAT_LD(PAT_LD), .THR(THR), .IRQ_CLR(IRQ_CLR),
        .HIT(HIT), .CNT(CNT), .IRQ(IRQ), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern load in IDLE, optionally with a count/IRQ clear on the same edge.
    task automatic load_pat(input logic [W-1:0] p, input logic clr);
        PAT = p; PAT_LD = 1'b1; IRQ_CLR = clr;
        tick();
        PAT_LD = 1'b0; IRQ_CLR = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; PVLD = 1'b0; PAT_LD = 1'b0; IRQ_CLR = 1'b0;
        PDIN = '0; PAT = '0; THR = '0;
        tick(); tick();
        chk("rst_prdy", PRDY, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_hit",  HIT,  1'b0);
        chk("rst_cnt",  CNT,  8'd0);
        chk("rst_irq",  IRQ,  1'b0);
        RST = 1'b0;
        tick();
        chk("idle_prdy", PRDY, 1'b1);

        // Single D3 word: HIT only between E8 and E9.
        load_pat(8'hD3, 1'b0);
        PDIN = 8'hD3; PVLD = 1'b1;
        tick();                                   // E0
        PVLD = 1'b0;
        chk("single_busy", BUSY, 1'b1);
        hits = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            hits[k] = HIT;
        end
        chk("single_hits", hits, 17'h00100);
        chk("single_cnt",  CNT, 8'd1);
        chk("single_idle", BUSY, 1'b0);

        // Back-to-back D3,4C: overlapping hit 6 cycles later, IRQ at THR=2.
        THR = 8'd2;
        load_pat(8'hD3, 1'b1);
        PDIN = 8'hD3; PVLD = 1'b1;
        tick();                                   // E0
        PDIN = 8'h4C;
        hits = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            hits[k] = HIT;
            if (k == 7)  chk("b2b_prdy_last", PRDY, 1'b1);
            if (k == 8)  begin chk("b2b_busy_gap", BUSY, 1'b1); PVLD = 1'b0; end
            if (k == 9)  chk("b2b_cnt1", CNT, 8'd1);
            if (k == 14) chk("b2b_irq_pre", IRQ, 1'b0);
            if (k == 15) begin chk("b2b_cnt2", CNT, 8'd2); chk("b2b_irq", IRQ, 1'b1); end
        end
        chk("b2b_hits", hits, 17'h04100);
        chk("b2b_done", BUSY, 1'b0);

        // Same traffic, IRQ_CLR on the edge that consumes the second HIT.
        load_pat(8'hD3, 1'b1);
        chk("clr_irq", IRQ, 1'b0);
        PDIN = 8'hD3; PVLD = 1'b1;
        tick();
        PDIN = 8'h4C;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 8)  PVLD = 1'b0;
            if (k == 14) begin chk("sameclr_hit", HIT, 1'b1); IRQ_CLR = 1'b1; end
            if (k == 15) begin
                IRQ_CLR = 1'b0;
                chk("sameclr_cnt", CNT, 8'd1);
                chk("sameclr_irq", IRQ, 1'b0);
            end
        end

        // Reset in the 4th SHIFT cycle, then a fresh word.
        THR = '0;
        load_pat(8'hD3, 1'b0);
        PDIN = 8'hD3; PVLD = 1'b1;
        tick();
        PVLD = 1'b0;
        tick(); tick(); tick();
        RST = 1'b1;
        chk("midrst_prdy", PRDY, 1'b0);
        tick();
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_cnt",  CNT,  8'd0);
        chk("midrst_hit",  HIT,  1'b0);
        RST = 1'b0;
        load_pat(8'hD3, 1'b0);
        PDIN = 8'hD3; PVLD = 1'b1;
        tick();
        PVLD = 1'b0;
        hits = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            hits[k] = HIT;
        end
        chk("postrst_hits", hits, 17'h00100);

        // Saturation: all-zero stream against pattern 00 hits every bit.
        load_pat(8'h00, 1'b1);
        PDIN = 8'h00; PVLD = 1'b1;
        tick();                                   // E0
        for (int j = 1; j <= 270; j++) tick();
        chk("sat_cnt", CNT, 8'd255);
        chk("sat_hit", HIT, 1'b1);
        PAT = 8'hFF; PAT_LD = 1'b1;               // ignored: always in SHIFT
        for (int j = 0; j < 10; j++) tick();
        PAT_LD = 1'b0;
        chk("patld_shift_hit", HIT, 1'b1);
        chk("patld_shift_cnt", CNT, 8'd255);
        chk("sat_irq_thr0",    IRQ, 1'b0);

        // Dropping EN mid-word lets it finish and blocks further words.
        EN = 1'b0;
        chk("en_off_busy", BUSY, 1'b1);
        for (int j = 0; j < 9; j++) tick();
        chk("en_off_idle", BUSY, 1'b0);
        chk("en_off_prdy", PRDY, 1'b0);
        tick();
        chk("en_off_stay", BUSY, 1'b0);
        PVLD = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
